// File: rtl/tx_in_buffer.sv
// rtl/tx_in_buffer.sv - payload word buffer serialized LSB-of-last-word first on modulator strobes
module tx_in_buffer #(
    parameter int NUM_WORDS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_ena,
    input  logic [2:0]  write_address,
    input  logic [31:0] write_data,
    input  logic        flag_write_ena,
    input  logic        flag_addres,
    input  logic [31:0] flag_data,
    input  logic        bit_ena,
    output logic        dout,
    output logic        dout_valid,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int FRAME_BITS = NUM_WORDS * 32;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [31:0]           words [NUM_WORDS];
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] load_vec;
    logic [CNT_W-1:0]      bit_cnt;

    logic flag_hit;
    logic start_req;
    logic clear_req;
    logic addr_ok;
    logic word_wr;
    logic frame_end;
    logic shift_en;

    assign flag_hit  = flag_write_ena && (flag_addres == 1'b0);
    assign start_req = flag_hit && (flag_data == 32'h1);
    assign clear_req = flag_hit && (flag_data == 32'h0);
    assign addr_ok   = ({1'b0, write_address} < 4'(NUM_WORDS));
    assign word_wr   = write_ena && addr_ok && (state != SEND);
    assign frame_end = (bit_cnt == CNT_W'(FRAME_BITS));
    // Abort and frame completion both take priority over a pending bit strobe
    assign shift_en  = (state == SEND) && !clear_req && !frame_end && bit_ena;

    assign tx_busy = (state == SEND);
    assign tx_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = SEND;
            SEND:    if (clear_req) state_nxt = IDLE;
                     else if (frame_end) state_nxt = DONE;
            DONE:    if (clear_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame image with any same-cycle word write folded in; word 0 lands at the MSBs
    always_comb begin
        load_vec = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            load_vec[32*(NUM_WORDS-1-k) +: 32] =
                (word_wr && (write_address == 3'(k))) ? write_data : words[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                words[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (word_wr && (write_address == 3'(k))) begin
                    words[k] <= write_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if ((state == IDLE) && start_req) begin
                shift_q <= load_vec;
                bit_cnt <= '0;
                dout    <= 1'b0;
            end else if ((state == SEND) && clear_req) begin
                shift_q <= '0;
                bit_cnt <= '0;
                dout    <= 1'b0;
            end else if (shift_en) begin
                dout       <= shift_q[0];
                shift_q    <= {1'b0, shift_q[FRAME_BITS-1:1]};
                bit_cnt    <= bit_cnt + CNT_W'(1);
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tx_in_buffer.md
TX_IN_BUFFER -- requirements
Module: tx_in_buffer

Interface
REQ-001 Parameter: NUM_WORDS, default 7, number of 32-bit payload words per frame (legal range 1..8); frame length is NUM_WORDS*32 bits (224 at default).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 write_ena  input  1  payload word write strobe.
REQ-005 write_address  input  3  payload word index.
REQ-006 write_data  input  32  payload word.
REQ-007 flag_write_ena  input  1  control flag write strobe.
REQ-008 flag_addres  input  1  control flag address; only address 0 is defined.
REQ-009 flag_data  input  32  control value; 32'h1 = start, 32'h0 = clear/abort.
REQ-010 bit_ena  input  1  serial bit strobe from modulator; one bit is consumed per asserted cycle.
REQ-011 dout  output  1  registered serial data bit.
REQ-012 dout_valid  output  1  one-cycle pulse marking a new dout bit.
REQ-013 tx_busy  output  1  high while the frame is being serialized.
REQ-014 tx_done  output  1  high from frame completion until cleared.

Function
REQ-015 Storage: NUM_WORDS x 32-bit word registers plus a NUM_WORDS*32-bit shift register and a bit counter wide enough for NUM_WORDS*32.
REQ-016 FSM states: IDLE, SEND, DONE.
REQ-017 In IDLE and DONE, write_ena=1 with write_address<NUM_WORDS stores write_data in that word.
REQ-018 Writes with write_address>=NUM_WORDS are ignored.
REQ-019 Writes in SEND are ignored, and stored words stay unchanged.
REQ-020 Start condition: flag_write_ena=1, flag_addres=0, flag_data=32'h1.
REQ-021 Start in IDLE: next cycle the state is SEND, tx_busy=1, counter=0, and the shift register is loaded with word k at bits [32*(NUM_WORDS-1-k)+31 : 32*(NUM_WORDS-1-k)].
REQ-022 With the default NUM_WORDS=7, word 0 sits at [223:192] and word 6 at [31:0].
REQ-023 If write_ena and start occur in the same cycle, the write is applied first and the loaded shift register includes the new word.
REQ-024 In SEND with bit_ena=1: dout <= shift[0]; shift register shifts right by one; counter increments; dout_valid=1 for that cycle.
REQ-025 Transmission order is word NUM_WORDS-1 bit 0 first and word 0 bit 31 last, so a receiver shifting in at the MSB returns identical word addresses.
REQ-026 In SEND with bit_ena=0: dout, the shift register and the counter hold, and dout_valid=0.
REQ-027 When the counter reaches NUM_WORDS*32 (the cycle after the last bit is emitted), the state goes to DONE with tx_busy=0 and tx_done=1.
REQ-028 The last dout value holds until the next emitted bit, start or reset.
REQ-029 bit_ena in IDLE or DONE is ignored, and dout_valid stays 0.
REQ-030 Clear (flag_write_ena=1, flag_addres=0, flag_data=32'h0) in DONE: state IDLE and tx_done=0.
REQ-031 Clear in SEND aborts the frame: state IDLE, tx_busy=0, counter=0, dout=0, and no further dout_valid.
REQ-032 Start in SEND or DONE is ignored; a new frame requires a clear first.
REQ-033 Flag writes with flag_addres=1 or any other flag_data value are ignored.
REQ-034 Latency: the first dout_valid occurs on the first bit_ena cycle after the SEND entry edge.

Reset
REQ-035 rst_n=0 immediately forces: state IDLE, all word registers, shift register and counter to 0, and dout=0, dout_valid=0, tx_busy=0, tx_done=0.
REQ-036 Reset asserted mid-frame aborts the frame with no further dout_valid; operation resumes on the first clock edge after rst_n deasserts.

Verification
REQ-037 Write words 0..6 = 32'h0000_0001..32'h0000_0007, start, bit_ena held high -> first dout bit=1 (word 6 bit 0); exactly 224 dout_valid pulses; tx_done=1 on the cycle after the 224th pulse.
REQ-038 Same frame with bit_ena asserted every 4th cycle -> identical 224-bit sequence, dout stable between pulses, tx_busy high throughout.
REQ-039 Loopback: feed dout/dout_valid into an MSB-shift-in receiver -> after 224 bits the receiver's word k equals the written word k for all k.
REQ-040 Writes of 32'hFFFF_FFFF to address 2 during SEND and to address 7 in IDLE -> transmitted and stored data unchanged.
REQ-041 Clear after 100 bits -> IDLE, dout=0, no further dout_valid; then a new start -> full 224-bit frame from bit 0.
REQ-042 rst_n low at bit 50 -> all outputs 0 immediately and words zeroed; after release, start -> 224 zero bits, then tx_done=1.
